// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one RAM port between an instruction fetch path and a data path.
// Data is favoured, but a bounded streak counter stops it from starving instruction fetches.
module ram_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int WAIT_MAX   = 15
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  input  logic [31:0] ramload,
  input  logic        busy_o,
  output logic        Ren,
  output logic        Wen,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  output logic [31:0] iload,
  output logic [31:0] dload,
  output logic        i_ready,
  output logic        d_ready,
  output logic        timeout_err
);

  localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam int WW = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [WW-1:0] WAIT_LIM   = WW'(WAIT_MAX);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_IACC = 2'd1,
    S_DACC = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          ren_q, ren_d;
  logic          wen_q, wen_d;
  logic          wr_q, wr_d;
  logic          iready_q, iready_d;
  logic          dready_q, dready_d;
  logic          timeout_q, timeout_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   store_q, store_d;
  logic [31:0]   iload_q, iload_d;
  logic [31:0]   dload_q, dload_d;
  logic [SW-1:0] dstreak_q, dstreak_d;
  logic [WW-1:0] waitcnt_q, waitcnt_d;

  logic dreq_s;
  logic istarved_s;
  logic can_grant_s;
  logic grant_i_s;
  logic grant_d_s;
  logic abort_s;
  logic end_s;

  // No grant while a ready pulse is out: that cycle is the recovery gap between accesses.
  assign dreq_s      = dREN | dWEN;
  assign istarved_s  = iREN && (dstreak_q == STARVE_LIM);
  assign can_grant_s = (state_q == S_IDLE) && !iready_q && !dready_q;
  assign grant_i_s   = can_grant_s && (istarved_s || (iREN && !dreq_s));
  assign grant_d_s   = can_grant_s && !istarved_s && dreq_s;
  assign abort_s     = busy_o && (waitcnt_q == WAIT_LIM);
  assign end_s       = (state_q != S_IDLE) && (!busy_o || abort_s);

  // Next-state and output decode for the IDLE/IACC/DACC controller.
  always_comb begin
    state_d   = state_q;
    ren_d     = 1'b0;
    wen_d     = 1'b0;
    wr_d      = wr_q;
    iready_d  = 1'b0;
    dready_d  = 1'b0;
    timeout_d = timeout_q;
    addr_d    = addr_q;
    store_d   = store_q;
    iload_d   = iload_q;
    dload_d   = dload_q;
    dstreak_d = dstreak_q;
    waitcnt_d = waitcnt_q;

    case (state_q)
      S_IDLE: begin
        if (grant_i_s || !iREN) begin
          dstreak_d = {SW{1'b0}};
        end else if (grant_d_s && (dstreak_q != STARVE_LIM)) begin
          dstreak_d = dstreak_q + SW'(1);
        end else begin
          dstreak_d = dstreak_q;
        end

        if (grant_i_s) begin
          state_d   = S_IACC;
          addr_d    = iaddr;
          wr_d      = 1'b0;
          ren_d     = 1'b1;
          waitcnt_d = {WW{1'b0}};
        end else if (grant_d_s) begin
          // A simultaneous dREN/dWEN pair is a write.
          state_d   = S_DACC;
          addr_d    = daddr;
          store_d   = dstore;
          wr_d      = dWEN;
          ren_d     = !dWEN;
          wen_d     = dWEN;
          waitcnt_d = {WW{1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end

      S_IACC, S_DACC: begin
        if (end_s) begin
          state_d   = S_IDLE;
          timeout_d = timeout_q | abort_s;
          if (state_q == S_IACC) begin
            iready_d = 1'b1;
            iload_d  = abort_s ? 32'h0000_0000 : ramload;
          end else begin
            dready_d = 1'b1;
            if (!wr_q) begin
              dload_d = abort_s ? 32'h0000_0000 : ramload;
            end else begin
              dload_d = dload_q;
            end
          end
        end else begin
          ren_d     = ren_q;
          wen_d     = wen_q;
          waitcnt_d = waitcnt_q + WW'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops strobes and clears all visible state at once.
  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      state_q   <= S_IDLE;
      ren_q     <= 1'b0;
      wen_q     <= 1'b0;
      wr_q      <= 1'b0;
      iready_q  <= 1'b0;
      dready_q  <= 1'b0;
      timeout_q <= 1'b0;
      addr_q    <= 32'h0000_0000;
      store_q   <= 32'h0000_0000;
      iload_q   <= 32'h0000_0000;
      dload_q   <= 32'h0000_0000;
      dstreak_q <= {SW{1'b0}};
      waitcnt_q <= {WW{1'b0}};
    end else begin
      state_q   <= state_d;
      ren_q     <= ren_d;
      wen_q     <= wen_d;
      wr_q      <= wr_d;
      iready_q  <= iready_d;
      dready_q  <= dready_d;
      timeout_q <= timeout_d;
      addr_q    <= addr_d;
      store_q   <= store_d;
      iload_q   <= iload_d;
      dload_q   <= dload_d;
      dstreak_q <= dstreak_d;
      waitcnt_q <= waitcnt_d;
    end
  end

  assign Ren         = ren_q;
  assign Wen         = wen_q;
  assign ramaddr     = addr_q;
  assign ramstore    = store_q;
  assign iload       = iload_q;
  assign dload       = dload_q;
  assign i_ready     = iready_q;
  assign d_ready     = dready_q;
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Randomized scoreboard bench for ram_arbiter: requester agents push expected results,
// a RAM responder model drives busy_o/ramload, and monitors check grants and returned words.
module tb_ram_arbiter;
  localparam int STARVE_MAX = 4;
  localparam int WAIT_MAX   = 15;

  logic        CLK = 1'b0;
  logic        nRST = 1'b1;
  logic        iREN = 1'b0;
  logic [31:0] iaddr = 32'h0;
  logic        dREN = 1'b0;
  logic        dWEN = 1'b0;
  logic [31:0] daddr = 32'h0;
  logic [31:0] dstore = 32'h0;
  logic [31:0] ramload = 32'h0;
  logic        busy_o = 1'b0;
  logic        Ren, Wen, i_ready, d_ready, timeout_err;
  logic [31:0] ramaddr, ramstore, iload, dload;

  ram_arbiter #(.STARVE_MAX(STARVE_MAX), .WAIT_MAX(WAIT_MAX)) dut (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
    .daddr(daddr), .dstore(dstore), .ramload(ramload), .busy_o(busy_o),
    .Ren(Ren), .Wen(Wen), .ramaddr(ramaddr), .ramstore(ramstore), .iload(iload),
    .dload(dload), .i_ready(i_ready), .d_ready(d_ready), .timeout_err(timeout_err)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  logic [31:0] ram [16];
  logic [31:0] shadow [16];
  int          i_lat = 0;
  int          d_lat = 0;
  int          cur_lat = 0;
  int          acc_k = 0;
  bit          mon_en = 1'b0;
  logic [31:0] iq [$];
  logic [31:0] dq [$];
  bit          ito_q [$];
  bit          dto_q [$];
  logic [31:0] last_d_model = 32'h0;
  logic [31:0] mon_last_i = 32'h0;
  logic [31:0] mon_last_d = 32'h0;
  bit          exp_to = 1'b0;
  int          starve_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rom(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0050_0093;
  endfunction

  function automatic int pick_lat();
    int r;
    r = $urandom_range(0, 19);
    if (r == 0) return $urandom_range(16, 20);
    else if (r < 3) return $urandom_range(5, 15);
    else return $urandom_range(0, 3);
  endfunction

  task automatic wait_ready(input bit is_d);
    int n;
    n = 0;
    forever begin
      @(negedge CLK);
      if ((is_d ? d_ready : i_ready) === 1'b1) break;
      n++;
      if (n > 200) begin
        checks++;
        errors++;
        $display("FAIL ready_wait port=%0d: got no ready, expected one within 200 cycles", is_d);
        break;
      end
    end
  endtask

  task automatic wait_dstrobe();
    int n;
    n = 0;
    forever begin
      @(negedge CLK);
      if ((Ren | Wen) && ramaddr[31]) break;
      n++;
      if (n > 200) begin
        checks++;
        errors++;
        $display("FAIL dstrobe_wait: got no data strobe, expected one within 200 cycles");
        break;
      end
    end
  endtask

  task automatic instr_agent(input int n, input int max_gap, input int force_lat);
    for (int t = 0; t < n; t++) begin
      int lat;
      logic [31:0] a;
      if (max_gap > 0) repeat ($urandom_range(0, max_gap)) @(negedge CLK);
      lat = (force_lat >= 0) ? force_lat : pick_lat();
      a = (t == 0 && force_lat >= 0) ? 32'h0000_0100 : (32'($urandom_range(0, 1023)) << 2);
      i_lat = lat;
      iaddr = a;
      iREN = 1'b1;
      iq.push_back((lat > WAIT_MAX) ? 32'h0 : rom(a));
      ito_q.push_back(lat > WAIT_MAX);
      wait_ready(1'b0);
      iREN = 1'b0;
    end
  endtask

  task automatic data_agent(input int n, input int max_gap, input int force_lat, input int force_op);
    for (int t = 0; t < n; t++) begin
      int idx, lat, op;
      bit to, drop;
      logic [31:0] wv, exp;
      if (max_gap > 0) repeat ($urandom_range(0, max_gap)) @(negedge CLK);
      idx  = $urandom_range(0, 15);
      lat  = (force_lat >= 0) ? force_lat : pick_lat();
      op   = (force_op >= 0) ? force_op : $urandom_range(0, 2);
      to   = (lat > WAIT_MAX);
      drop = ($urandom_range(0, 3) == 0);
      wv   = $urandom;
      d_lat  = lat;
      daddr  = 32'h8000_0000 | (32'(idx) << 2);
      dstore = wv;
      if (op == 0) begin
        dREN = 1'b1;
        dWEN = 1'b0;
        exp = to ? 32'h0 : shadow[idx];
        last_d_model = exp;
      end else begin
        dWEN = 1'b1;
        dREN = 1'($urandom_range(0, 1));
        if (!to) shadow[idx] = wv;
        exp = last_d_model;
      end
      dq.push_back(exp);
      dto_q.push_back(to);
      if (drop) begin
        wait_dstrobe();
        dREN = 1'b0;
        dWEN = 1'b0;
        daddr = $urandom;
        dstore = $urandom;
      end
      wait_ready(1'b1);
      dREN = 1'b0;
      dWEN = 1'b0;
    end
  endtask

  // RAM responder: busy for the requester-chosen latency, then returns/commits data.
  initial begin
    forever begin
      @(negedge CLK);
      if (nRST) begin
        acc_k = 0;
        busy_o = 1'b0;
      end else if (Ren | Wen) begin
        if (acc_k == 0) cur_lat = ramaddr[31] ? d_lat : i_lat;
        busy_o = (acc_k < cur_lat);
        if (busy_o) ramload = $urandom;
        else ramload = ramaddr[31] ? ram[ramaddr[5:2]] : rom(ramaddr);
        if (!busy_o && Wen) ram[ramaddr[5:2]] = ramstore;
        acc_k++;
      end else begin
        acc_k = 0;
        busy_o = 1'($urandom_range(0, 1));
        ramload = $urandom;
      end
    end
  end

  // Grant monitor: arbitration rule, streak limit, held address and access length.
  initial begin
    bit prev_strobe, prev_ready, strobe, dpend, is_i, must_grant;
    int streak, acc_len, exp_len;
    logic [31:0] held_addr;
    logic [1:0] held_rw;
    prev_strobe = 1'b0; prev_ready = 1'b0; streak = 0; acc_len = 0;
    held_addr = 32'h0; held_rw = 2'b00;
    forever begin
      @(posedge CLK);
      #1;
      strobe = Ren | Wen;
      if (mon_en) begin
        chk("ren_wen_exclusive", 32'(Ren & Wen), 32'h0);
        dpend = dREN | dWEN;
        if (!prev_strobe) begin
          must_grant = !prev_ready && (iREN || dpend);
          chk("grant_decision", 32'(strobe), 32'(must_grant));
          if (!iREN) streak = 0;
        end
        if (strobe && !prev_strobe) begin
          is_i = !ramaddr[31];
          if (iREN && streak == STARVE_MAX) begin
            chk("starve_grant_instr", 32'(is_i), 32'h1);
            if (dpend) starve_seen++;
          end else if (dpend) begin
            chk("data_priority", 32'(is_i), 32'h0);
          end
          if (is_i) begin
            chk("igrant_addr", ramaddr, iaddr);
            chk("igrant_strobes", 32'({Ren, Wen}), 32'h2);
            streak = 0;
          end else begin
            chk("dgrant_addr", ramaddr, daddr);
            chk("dgrant_strobes", 32'({Ren, Wen}), 32'({~dWEN, dWEN}));
            if (dWEN) chk("dgrant_store", ramstore, dstore);
            if (iREN && streak < STARVE_MAX) streak++;
          end
          held_addr = ramaddr;
          held_rw = {Ren, Wen};
          acc_len = 1;
        end else if (strobe) begin
          chk("held_addr", ramaddr, held_addr);
          chk("held_strobes", 32'({Ren, Wen}), 32'(held_rw));
          acc_len++;
        end else if (prev_strobe) begin
          exp_len = ((cur_lat > WAIT_MAX) ? WAIT_MAX : cur_lat) + 1;
          chk("access_len", 32'(acc_len), 32'(exp_len));
        end
      end
      prev_strobe = strobe;
      prev_ready = i_ready | d_ready;
    end
  end

  // Scoreboard monitor: pops expected words on ready pulses and checks held outputs.
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      if (mon_en) begin
        if (i_ready) begin
          if (iq.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_i_ready: got pulse, expected none");
          end else begin
            mon_last_i = iq.pop_front();
            if (ito_q.pop_front()) exp_to = 1'b1;
          end
        end
        if (d_ready) begin
          if (dq.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_d_ready: got pulse, expected none");
          end else begin
            mon_last_d = dq.pop_front();
            if (dto_q.pop_front()) exp_to = 1'b1;
          end
        end
        chk("iload", iload, mon_last_i);
        chk("dload", dload, mon_last_d);
        chk("timeout_err", 32'(timeout_err), 32'(exp_to));
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got no end of test, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      ram[i] = 32'h1000 + 32'(i);
      shadow[i] = 32'h1000 + 32'(i);
    end
    // Reset values, with a data request already waiting.
    dREN = 1'b1;
    daddr = 32'h8000_000C;
    d_lat = 10;
    repeat (2) @(negedge CLK);
    chk("rst_ren", 32'(Ren), 32'h0);
    chk("rst_wen", 32'(Wen), 32'h0);
    chk("rst_i_ready", 32'(i_ready), 32'h0);
    chk("rst_d_ready", 32'(d_ready), 32'h0);
    chk("rst_timeout", 32'(timeout_err), 32'h0);
    chk("rst_ramaddr", ramaddr, 32'h0);
    chk("rst_ramstore", ramstore, 32'h0);
    chk("rst_iload", iload, 32'h0);
    chk("rst_dload", dload, 32'h0);
    nRST = 1'b0;
    #1 chk("no_grant_before_edge", 32'(Ren), 32'h0);
    @(posedge CLK);
    #1;
    chk("first_edge_grant", 32'(Ren), 32'h1);
    chk("first_edge_addr", ramaddr, 32'h8000_000C);
    // Reset in the middle of the data access.
    @(negedge CLK);
    #2 nRST = 1'b1;
    #1;
    chk("midrst_ren", 32'(Ren), 32'h0);
    chk("midrst_wen", 32'(Wen), 32'h0);
    chk("midrst_ramaddr", ramaddr, 32'h0);
    dREN = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      if (k == 2) nRST = 1'b0;
      chk("midrst_no_d_ready", 32'(d_ready), 32'h0);
    end
    d_lat = 2;
    dREN = 1'b1;
    wait_ready(1'b1);
    chk("fresh_read_dload", dload, shadow[3]);
    dREN = 1'b0;
    last_d_model = shadow[3];
    mon_last_d = shadow[3];
    mon_en = 1'b1;

    instr_agent(1, 0, 2);
    fork
      instr_agent(1, 0, 1);
      data_agent(1, 0, 1, 1);
    join
    data_agent(1, 0, 20, 0);
    fork
      instr_agent(20, 0, -1);
      data_agent(40, 0, -1, -1);
    join
    fork
      instr_agent(40, 3, -1);
      data_agent(40, 3, -1, -1);
    join
    repeat (5) @(negedge CLK);
    chk("iq_drained", 32'(iq.size()), 32'h0);
    chk("dq_drained", 32'(dq.size()), 32'h0);
    chk("starvation_grant_seen", 32'(starve_seen > 0), 32'h1);
    chk("timeout_sticky", 32'(timeout_err), 32'h1);
    mon_en = 1'b0;
    nRST = 1'b1;
    #1 chk("timeout_cleared_by_reset", 32'(timeout_err), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
